puzzle_board: RTL and testbench

//  Downstream consumer of the shuffle ROM. On start_load it walks ROM addresses 0..15, copies the 16 tile codes

---
 rtl/puzzle_board.sv | 129 ++++++++++++
 tb/tb_puzzle_board.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/puzzle_board.sv
// puzzle_board: 4x4 sliding-puzzle board held in registers.
//   A load request walks ROM addresses 0..15 and copies the tile codes into
//   the board. It also latches the empty-slot position that the ROM reports.
//   In READY, player moves swap the empty slot with one of its neighbours.
//   The block counts legal moves and flags the solved arrangement.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   start_load, seed      load request and shuffle selection
//   shuffle_idx, rom_addr ROM lookup (rom_addr[4] is always 0)
//   rom_data, rom_empty   ROM tile code and empty-slot position (combinational)
//   move_valid, move_dir  move request (00 up, 01 down, 10 left, 11 right)
//   rd_addr, rd_data      zero-latency display read port
//   busy, ready           loading / ready-for-moves status
//   empty_pos             current empty-slot position
//   move_done/illegal     one-cycle result pulses
//   move_count, solved    saturating move counter, solved flag
module puzzle_board #(
  parameter int MAX_MOVES = 999,
  parameter int COUNT_W   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_load,
  input  logic [2:0]         seed,
  output logic [2:0]         shuffle_idx,
  output logic [4:0]         rom_addr,
  input  logic [3:0]         rom_data,
  input  logic [3:0]         rom_empty,
  input  logic               move_valid,
  input  logic [1:0]         move_dir,
  input  logic [3:0]         rd_addr,
  output logic [3:0]         rd_data,
  output logic               busy,
  output logic               ready,
  output logic [3:0]         empty_pos,
  output logic               move_done,
  output logic               move_illegal,
  output logic [COUNT_W-1:0] move_count,
  output logic               solved
);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t           state;
  logic [3:0]       idx;
  logic [15:0][3:0] board;
  logic             legal;
  logic [3:0]       nbr;
  logic             in_order;

  assign rom_addr = {1'b0, idx};
  assign busy     = (state == LOAD);
  assign ready    = (state == READY);
  // IDLE is reachable only through reset, so the board is all zero there.
  // The gate makes the zero read explicit.
  assign rd_data  = (state == IDLE) ? 4'd0 : board[rd_addr];

  // Edge checks use the row and column fields of the current empty slot.
  always_comb begin
    legal = 1'b0;
    nbr   = empty_pos;
    unique case (move_dir)
      2'b00: begin legal = (empty_pos[3:2] != 2'd0); nbr = empty_pos - 4'd4; end
      2'b01: begin legal = (empty_pos[3:2] != 2'd3); nbr = empty_pos + 4'd4; end
      2'b10: begin legal = (empty_pos[1:0] != 2'd0); nbr = empty_pos - 4'd1; end
      2'b11: begin legal = (empty_pos[1:0] != 2'd3); nbr = empty_pos + 4'd1; end
    endcase
  end

  // Target board is {1,2,...,15,0}. At position 15, i+1 truncates to 4 bits and gives 0.
  always_comb begin
    in_order = 1'b1;
    for (int i = 0; i < 16; i++)
      if (board[i] != 4'(i + 1)) in_order = 1'b0;
  end
  assign solved = in_order & ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      board        <= '0;
      empty_pos    <= '0;
      move_count   <= '0;
      shuffle_idx  <= '0;
      move_done    <= 1'b0;
      move_illegal <= 1'b0;
    end else begin
      move_done    <= 1'b0;
      move_illegal <= 1'b0;
      // A load request takes priority in every state.
      // In LOAD it restarts the walk, and in READY it drops a simultaneous move.
      if (start_load) begin
        shuffle_idx <= seed;
        idx         <= '0;
        state       <= LOAD;
      end else begin
        case (state)
          LOAD: begin
            board[idx] <= rom_data;
            if (idx == 4'd0) empty_pos <= rom_empty;
            idx <= idx + 4'd1;
            if (idx == 4'd15) begin
              state      <= READY;
              move_count <= '0;
            end
          end
          READY: begin
            if (move_valid) begin
              if (legal) begin
                board[empty_pos] <= board[nbr];
                board[nbr]       <= 4'd0;
                empty_pos        <= nbr;
                move_done        <= 1'b1;
                if (move_count != COUNT_W'(MAX_MOVES))
                  move_count <= move_count + 1'b1;
              end else begin
                move_illegal <= 1'b1;
              end
            end
          end
          IDLE:    ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_puzzle_board.sv
// tb_puzzle_board: directed test of puzzle_board against a small shuffle ROM.
// Seed 0 gives the solved board. Seed 1 is a hand-made permutation with its
// empty slot at position 7. Seed 2 is the reversed board.
module tb_puzzle_board;
  logic        clk = 1'b0;
  logic        reset, start_load, move_valid;
  logic [2:0]  seed, shuffle_idx;
  logic [4:0]  rom_addr;
  logic [3:0]  rom_data, rom_empty, rd_addr, rd_data, empty_pos;
  logic [1:0]  move_dir;
  logic        busy, ready, move_done, move_illegal, solved;
  logic [9:0]  move_count;

  int checks = 0;
  int failures = 0;
  int seed1_tab[16] = '{13, 2, 3, 4, 1, 6, 7, 0, 9, 10, 11, 8, 14, 15, 12, 5};

  always #5 clk = ~clk;

  function automatic logic [3:0] rom_tile(input logic [2:0] s, input logic [3:0] a);
    case (s)
      3'd1:    return 4'(seed1_tab[a]);
      3'd2:    return 4'(15 - int'(a));
      default: return (a == 4'd15) ? 4'd0 : a + 4'd1;
    endcase
  endfunction

  function automatic logic [3:0] rom_hole(input logic [2:0] s);
    return (s == 3'd1) ? 4'd7 : 4'd15;
  endfunction

  assign rom_data  = rom_tile(shuffle_idx, rom_addr[3:0]);
  assign rom_empty = rom_hole(shuffle_idx);

  puzzle_board dut (
    .clk(clk), .reset(reset), .start_load(start_load), .seed(seed),
    .shuffle_idx(shuffle_idx), .rom_addr(rom_addr), .rom_data(rom_data),
    .rom_empty(rom_empty), .move_valid(move_valid), .move_dir(move_dir),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .ready(ready),
    .empty_pos(empty_pos), .move_done(move_done), .move_illegal(move_illegal),
    .move_count(move_count), .solved(solved)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] want, input string tag);
    rd_addr = a;
    #1;
    chk(tag, rd_data, want);
  endtask

  task automatic chk_board(input logic [2:0] s, input string tag);
    for (int a = 0; a < 16; a++) rd(4'(a), rom_tile(s, 4'(a)), tag);
  endtask

  // Issue start_load, then expect exactly 16 busy cycles with rom_addr walking 0..15.
  task automatic load(input logic [2:0] s, input string tag);
    start_load = 1'b1;
    seed = s;
    step();
    start_load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_addr"}, rom_addr, i);
      chk({tag, "_notrdy"}, ready, 0);
      step();
    end
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_count"}, move_count, 0);
    chk({tag, "_empty"}, empty_pos, rom_hole(s));
  endtask

  task automatic mv(input logic [1:0] d, input logic ok, input string tag);
    move_valid = 1'b1;
    move_dir = d;
    step();
    move_valid = 1'b0;
    chk({tag, "_done"}, move_done, ok);
    chk({tag, "_illegal"}, move_illegal, !ok);
  endtask

  initial begin
    reset = 1'b1; start_load = 1'b0; move_valid = 1'b0;
    seed = '0; move_dir = '0; rd_addr = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_solved", solved, 0);
    chk("rst_empty", empty_pos, 0);
    chk("rst_count", move_count, 0);
    chk("rst_shuf", shuffle_idx, 0);
    chk("rst_addr", rom_addr, 0);
    rd(4'd0, 4'd0, "rst_rd0");

    // A move request in IDLE is ignored.
    move_valid = 1'b1; move_dir = 2'b00;
    step();
    move_valid = 1'b0;
    chk("idle_mv_done", move_done, 0);
    chk("idle_mv_ill", move_illegal, 0);

    // Test 1: load seed 0, which gives the solved board.
    load(3'd0, "t1");
    rd(4'd0, 4'd1, "t1_rd0");
    rd(4'd15, 4'd0, "t1_rd15");
    chk("t1_solved", solved, 1);
    chk_board(3'd0, "t1_board");

    // Test 2: move up, then down, then left and right.
    mv(2'b00, 1'b1, "t2_up");
    rd(4'd15, 4'd12, "t2_rd15");
    rd(4'd11, 4'd0, "t2_rd11");
    chk("t2_empty", empty_pos, 11);
    chk("t2_solved", solved, 0);
    chk("t2_count", move_count, 1);
    step();
    chk("t2_pulse_clr", move_done, 0);
    mv(2'b01, 1'b1, "t2_down");
    chk("t2_solved2", solved, 1);
    chk("t2_count2", move_count, 2);
    mv(2'b10, 1'b1, "t2_left");
    chk("t2_empty_l", empty_pos, 14);
    rd(4'd15, 4'd15, "t2_rd15_l");
    mv(2'b11, 1'b1, "t2_right");
    chk("t2_empty_r", empty_pos, 15);
    chk("t2_count4", move_count, 4);

    // Test 3: with the empty slot at the bottom-right corner, down and right are illegal.
    load(3'd0, "t3");
    mv(2'b01, 1'b0, "t3_down");
    mv(2'b11, 1'b0, "t3_right");
    chk("t3_empty", empty_pos, 15);
    chk("t3_count", move_count, 0);
    chk("t3_solved", solved, 1);
    chk_board(3'd0, "t3_board");

    // Test 4: load seed 1. The empty slot is at 7 (row 1, column 3).
    load(3'd1, "t4");
    rd(4'd0, 4'd13, "t4_rd0");
    rd(4'd7, 4'd0, "t4_rd7");
    rd(4'd15, 4'd5, "t4_rd15");
    chk("t4_solved", solved, 0);
    chk_board(3'd1, "t4_board");
    mv(2'b11, 1'b0, "t4_right");
    mv(2'b00, 1'b1, "t4_up");
    rd(4'd7, 4'd4, "t4_rd7b");
    rd(4'd3, 4'd0, "t4_rd3");
    mv(2'b00, 1'b0, "t4_up_top");
    mv(2'b10, 1'b1, "t4_left");
    rd(4'd3, 4'd3, "t4_rd3b");
    rd(4'd2, 4'd0, "t4_rd2");
    chk("t4_empty", empty_pos, 2);
    chk("t4_count", move_count, 2);

    // A load and a move in the same cycle: the load wins.
    start_load = 1'b1; seed = 3'd0; move_valid = 1'b1; move_dir = 2'b10;
    step();
    start_load = 1'b0; move_valid = 1'b0;
    chk("lw_busy", busy, 1);
    chk("lw_done", move_done, 0);
    chk("lw_ill", move_illegal, 0);
    repeat (16) step();
    chk("lw_ready", ready, 1);
    chk("lw_solved", solved, 1);

    // Test 5: start seed 2, then restart with seed 0 at load cycle 8.
    start_load = 1'b1; seed = 3'd2;
    step();
    start_load = 1'b0;
    repeat (8) step();
    load(3'd0, "t5");
    chk("t5_shuf", shuffle_idx, 0);
    chk("t5_solved", solved, 1);
    chk_board(3'd0, "t5_board");

    // Test 6: 1000 back-to-back up/down moves. The count saturates at 999.
    move_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      move_dir = (i % 2 == 0) ? 2'b00 : 2'b01;
      step();
      chk("t6_done", move_done, 1);
    end
    move_valid = 1'b0;
    chk("t6_count", move_count, 999);
    chk("t6_solved", solved, 1);

    // Reset in the middle of a load returns the block to IDLE.
    start_load = 1'b1; seed = 3'd1;
    step();
    start_load = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rl_busy", busy, 0);
    chk("rl_ready", ready, 0);
    chk("rl_empty", empty_pos, 0);
    chk("rl_count", move_count, 0);
    chk("rl_shuf", shuffle_idx, 0);
    chk("rl_addr", rom_addr, 0);
    for (int a = 0; a < 16; a++) rd(4'(a), 4'd0, "rl_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
